// File: rtl/dct_zigzag_serializer.sv
// Captures one 8x8 DCT coefficient block (64 parallel words) and streams it out one word per cycle
// in zig-zag or raster order over valid/ready. Define DCT_ZZ_DOUBLEBUF_EN for ping-pong block buffers.
module dct_zigzag_serializer #(
    parameter int DATA_W = 24,
    parameter int ZIGZAG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              blk_valid,
    input  logic [DATA_W-1:0] c0,  c1,  c2,  c3,  c4,  c5,  c6,  c7,
    input  logic [DATA_W-1:0] c8,  c9,  c10, c11, c12, c13, c14, c15,
    input  logic [DATA_W-1:0] c16, c17, c18, c19, c20, c21, c22, c23,
    input  logic [DATA_W-1:0] c24, c25, c26, c27, c28, c29, c30, c31,
    input  logic [DATA_W-1:0] c32, c33, c34, c35, c36, c37, c38, c39,
    input  logic [DATA_W-1:0] c40, c41, c42, c43, c44, c45, c46, c47,
    input  logic [DATA_W-1:0] c48, c49, c50, c51, c52, c53, c54, c55,
    input  logic [DATA_W-1:0] c56, c57, c58, c59, c60, c61, c62, c63,
    output logic              blk_ready,
    output logic [DATA_W-1:0] coef_out,
    output logic [5:0]        coef_idx,
    output logic              coef_valid,
    output logic              coef_last,
    input  logic              out_ready,
    output logic              overflow
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [5:0] ZZ_SCAN [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Element k of the packed block is c<k>, i.e. raster index 8*row+col.
    logic [63:0][DATA_W-1:0] blk_in;
    assign blk_in = {
        c63, c62, c61, c60, c59, c58, c57, c56,
        c55, c54, c53, c52, c51, c50, c49, c48,
        c47, c46, c45, c44, c43, c42, c41, c40,
        c39, c38, c37, c36, c35, c34, c33, c32,
        c31, c30, c29, c28, c27, c26, c25, c24,
        c23, c22, c21, c20, c19, c18, c17, c16,
        c15, c14, c13, c12, c11, c10, c9,  c8,
        c7,  c6,  c5,  c4,  c3,  c2,  c1,  c0
    };

    state_t            state;
    state_t            state_next;
    logic [5:0]        step;
    logic [5:0]        scan;
    logic              capture;
    logic              xfer;
    logic              blk_done;
    logic              more_next;
    logic              ready_next;
    logic [DATA_W-1:0] rd_word;

    assign capture    = blk_valid & blk_ready;
    assign coef_valid = (state == STREAM);
    assign xfer       = coef_valid & out_ready;
    assign blk_done   = xfer & (step == 6'd63);
    assign scan       = (ZIGZAG != 0) ? ZZ_SCAN[step] : step;

    // Outputs follow the registered step, so a stall simply holds them.
    assign coef_idx  = coef_valid ? scan : 6'd0;
    assign coef_out  = coef_valid ? rd_word : '0;
    assign coef_last = coef_valid & (step == 6'd63);

`ifdef DCT_ZZ_DOUBLEBUF_EN
    logic [63:0][DATA_W-1:0] buf_mem [2];
    logic [1:0]              full;
    logic [1:0]              full_next;
    logic                    wr_sel;
    logic                    rd_sel;

    // NOTE: block buffers carry no reset; their contents are don't-care until a capture,
    // and keeping them out of the reset tree lets them map to plain storage.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_mem[wr_sel] <= blk_in;
        end
    end

    // Capture always targets the free buffer, so it never collides with the one being released.
    always_comb begin
        full_next = full;
        if (blk_done) begin
            full_next[rd_sel] = 1'b0;
        end
        if (capture) begin
            full_next[wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full   <= 2'b00;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            full <= full_next;
            if (capture) begin
                wr_sel <= ~wr_sel;
            end
            if (blk_done) begin
                rd_sel <= ~rd_sel;
            end
        end
    end

    assign more_next  = |full_next;
    assign ready_next = ~&full_next;
    assign rd_word    = buf_mem[rd_sel][scan];
`else
    logic [63:0][DATA_W-1:0] buf_mem;

    // NOTE: block buffers carry no reset; their contents are don't-care until a capture,
    // and keeping them out of the reset tree lets them map to plain storage.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_mem <= blk_in;
        end
    end

    assign more_next  = (state == IDLE) ? capture : ~blk_done;
    assign ready_next = ~more_next;
    assign rd_word    = buf_mem[scan];
`endif

    // NOTE: state_next is defaulted before the case so every path assigns it and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (blk_done && !more_next) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            step      <= 6'd0;
            blk_ready <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            blk_ready <= ready_next;
            if (state == IDLE) begin
                step <= 6'd0;
            end else if (xfer) begin
                // Wraps 63 -> 0 on the last transfer, ready for a queued block.
                step <= step + 6'd1;
            end
            if (blk_valid && !blk_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dct_zigzag_serializer.sv
// Directed bench for dct_zigzag_serializer: zig-zag and raster instances, backpressure,
// overflow / ping-pong (DCT_ZZ_DOUBLEBUF_EN) and asynchronous mid-stream reset.
module tb_dct_zigzag_serializer;

    localparam int DATA_W = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              blk_valid;
    logic              blk_valid_r;
    logic              out_ready;
    logic [DATA_W-1:0] c [64];

    logic              blk_ready,  coef_valid,  coef_last,  overflow;
    logic [DATA_W-1:0] coef_out;
    logic [5:0]        coef_idx;
    logic              blk_ready_r, coef_valid_r, coef_last_r, overflow_r;
    logic [DATA_W-1:0] coef_out_r;
    logic [5:0]        coef_idx_r;

    int total = 0;
    int bad   = 0;
    int zz [64];

    always #5 clk = ~clk;

    dct_zigzag_serializer #(.DATA_W(DATA_W), .ZIGZAG(1)) dut (
        .clk(clk), .reset(reset), .blk_valid(blk_valid),
        .c0(c[0]),   .c1(c[1]),   .c2(c[2]),   .c3(c[3]),   .c4(c[4]),   .c5(c[5]),   .c6(c[6]),   .c7(c[7]),
        .c8(c[8]),   .c9(c[9]),   .c10(c[10]), .c11(c[11]), .c12(c[12]), .c13(c[13]), .c14(c[14]), .c15(c[15]),
        .c16(c[16]), .c17(c[17]), .c18(c[18]), .c19(c[19]), .c20(c[20]), .c21(c[21]), .c22(c[22]), .c23(c[23]),
        .c24(c[24]), .c25(c[25]), .c26(c[26]), .c27(c[27]), .c28(c[28]), .c29(c[29]), .c30(c[30]), .c31(c[31]),
        .c32(c[32]), .c33(c[33]), .c34(c[34]), .c35(c[35]), .c36(c[36]), .c37(c[37]), .c38(c[38]), .c39(c[39]),
        .c40(c[40]), .c41(c[41]), .c42(c[42]), .c43(c[43]), .c44(c[44]), .c45(c[45]), .c46(c[46]), .c47(c[47]),
        .c48(c[48]), .c49(c[49]), .c50(c[50]), .c51(c[51]), .c52(c[52]), .c53(c[53]), .c54(c[54]), .c55(c[55]),
        .c56(c[56]), .c57(c[57]), .c58(c[58]), .c59(c[59]), .c60(c[60]), .c61(c[61]), .c62(c[62]), .c63(c[63]),
        .blk_ready(blk_ready), .coef_out(coef_out), .coef_idx(coef_idx), .coef_valid(coef_valid),
        .coef_last(coef_last), .out_ready(out_ready), .overflow(overflow)
    );

    dct_zigzag_serializer #(.DATA_W(DATA_W), .ZIGZAG(0)) dut_raster (
        .clk(clk), .reset(reset), .blk_valid(blk_valid_r),
        .c0(c[0]),   .c1(c[1]),   .c2(c[2]),   .c3(c[3]),   .c4(c[4]),   .c5(c[5]),   .c6(c[6]),   .c7(c[7]),
        .c8(c[8]),   .c9(c[9]),   .c10(c[10]), .c11(c[11]), .c12(c[12]), .c13(c[13]), .c14(c[14]), .c15(c[15]),
        .c16(c[16]), .c17(c[17]), .c18(c[18]), .c19(c[19]), .c20(c[20]), .c21(c[21]), .c22(c[22]), .c23(c[23]),
        .c24(c[24]), .c25(c[25]), .c26(c[26]), .c27(c[27]), .c28(c[28]), .c29(c[29]), .c30(c[30]), .c31(c[31]),
        .c32(c[32]), .c33(c[33]), .c34(c[34]), .c35(c[35]), .c36(c[36]), .c37(c[37]), .c38(c[38]), .c39(c[39]),
        .c40(c[40]), .c41(c[41]), .c42(c[42]), .c43(c[43]), .c44(c[44]), .c45(c[45]), .c46(c[46]), .c47(c[47]),
        .c48(c[48]), .c49(c[49]), .c50(c[50]), .c51(c[51]), .c52(c[52]), .c53(c[53]), .c54(c[54]), .c55(c[55]),
        .c56(c[56]), .c57(c[57]), .c58(c[58]), .c59(c[59]), .c60(c[60]), .c61(c[61]), .c62(c[62]), .c63(c[63]),
        .blk_ready(blk_ready_r), .coef_out(coef_out_r), .coef_idx(coef_idx_r), .coef_valid(coef_valid_r),
        .coef_last(coef_last_r), .out_ready(out_ready), .overflow(overflow_r)
    );

    // Zig-zag order derived by walking the anti-diagonals of the 8x8 block.
    task automatic build_zz();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
            end
        end
    endtask

    task automatic load_block(input int base, input int sign);
        for (int k = 0; k < 64; k++) c[k] = DATA_W'(base + sign * k);
    endtask

    task automatic test_reset();
        reset = 1'b0; blk_valid = 1'b0; blk_valid_r = 1'b0; out_ready = 1'b0;
        load_block(0, 1);
        repeat (2) @(negedge clk);
        total++;
        if (coef_valid !== 1'b0 || coef_last !== 1'b0 || coef_out !== '0 || coef_idx !== 6'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got v=%0b last=%0b out=%0h idx=%0d ovf=%0b want all 0",
                     coef_valid, coef_last, coef_out, coef_idx, overflow);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (blk_ready !== 1'b1) begin
            bad++; $display("FAIL reset_blk_ready got=%0b want=1", blk_ready);
        end
    endtask

    task automatic test_zigzag();
        load_block(0, 1);
        out_ready = 1'b1;
        total++;
        if (coef_valid !== 1'b0 || blk_ready !== 1'b1) begin
            bad++; $display("FAIL zz_idle got v=%0b rdy=%0b want v=0 rdy=1", coef_valid, blk_ready);
        end
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            total++;
            if (coef_valid !== 1'b1 || coef_idx !== 6'(zz[i]) || coef_out !== DATA_W'(zz[i]) || coef_last !== (i == 63)) begin
                bad++;
                $display("FAIL zz_step%0d got v=%0b idx=%0d out=%0h last=%0b want v=1 idx=%0d out=%0h last=%0b",
                         i, coef_valid, coef_idx, coef_out, coef_last, zz[i], zz[i], (i == 63));
            end
            @(negedge clk);
        end
        total++;
        if (coef_valid !== 1'b0 || blk_ready !== 1'b1) begin
            bad++; $display("FAIL zz_end got v=%0b rdy=%0b want v=0 rdy=1", coef_valid, blk_ready);
        end
    endtask

    task automatic test_raster();
        load_block(0, -1);
        out_ready = 1'b1;
        blk_valid_r = 1'b1;
        @(negedge clk);
        blk_valid_r = 1'b0;
        for (int i = 0; i < 64; i++) begin
            total++;
            if (coef_valid_r !== 1'b1 || coef_idx_r !== 6'(i) || coef_out_r !== DATA_W'(-i) || coef_last_r !== (i == 63)) begin
                bad++;
                $display("FAIL raster_step%0d got v=%0b idx=%0d out=%0h last=%0b want v=1 idx=%0d out=%0h last=%0b",
                         i, coef_valid_r, coef_idx_r, coef_out_r, coef_last_r, i, DATA_W'(-i), (i == 63));
            end
            @(negedge clk);
        end
        total++;
        if (coef_valid_r !== 1'b0 || blk_ready_r !== 1'b1) begin
            bad++; $display("FAIL raster_end got v=%0b rdy=%0b want v=0 rdy=1", coef_valid_r, blk_ready_r);
        end
    endtask

    task automatic test_backpressure();
        int pos = 0;
        int last_cnt = 0;
        load_block(100, 1);
        out_ready = 1'b0;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        for (int t = 0; t < 192; t++) begin
            total++;
            if (coef_valid !== 1'b1 || coef_idx !== 6'(zz[pos]) || coef_out !== DATA_W'(100 + zz[pos]) || coef_last !== (pos == 63)) begin
                bad++;
                $display("FAIL bp_cycle%0d got v=%0b idx=%0d out=%0h last=%0b want v=1 idx=%0d out=%0h last=%0b",
                         t, coef_valid, coef_idx, coef_out, coef_last, zz[pos], 100 + zz[pos], (pos == 63));
            end
            if (coef_last === 1'b1) last_cnt++;
            out_ready = (t % 3 == 2);
            if (out_ready) pos++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        total++;
        if (last_cnt != 3) begin
            bad++; $display("FAIL bp_last_hold got=%0d want=3", last_cnt);
        end
        total++;
        if (coef_valid !== 1'b0) begin
            bad++; $display("FAIL bp_end got v=%0b want=0", coef_valid);
        end
    endtask

`ifndef DCT_ZZ_DOUBLEBUF_EN
    task automatic test_overflow();
        load_block(1000, 1);
        out_ready = 1'b1;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            total++;
            if (coef_valid !== 1'b1 || coef_idx !== 6'(zz[i]) || coef_out !== DATA_W'(1000 + zz[i])) begin
                bad++;
                $display("FAIL ovf_step%0d got v=%0b idx=%0d out=%0h want v=1 idx=%0d out=%0h",
                         i, coef_valid, coef_idx, coef_out, zz[i], 1000 + zz[i]);
            end
            if (i == 11) begin
                total++;
                if (overflow !== 1'b1) begin
                    bad++; $display("FAIL ovf_set got=%0b want=1", overflow);
                end
            end
            if (i == 10) begin
                load_block(5000, 1);
                blk_valid = 1'b1;
            end else begin
                blk_valid = 1'b0;
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (coef_valid !== 1'b0 || overflow !== 1'b1) begin
                bad++; $display("FAIL ovf_after%0d got v=%0b ovf=%0b want v=0 ovf=1", k, coef_valid, overflow);
            end
            @(negedge clk);
        end
    endtask
`else
    task automatic test_double_buffer();
        load_block(4000, 1);
        out_ready = 1'b1;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        for (int j = 0; j < 128; j++) begin
            int base = (j < 64) ? 4000 : 6000;
            total++;
            if (coef_valid !== 1'b1 || coef_idx !== 6'(zz[j % 64]) || coef_out !== DATA_W'(base + zz[j % 64]) ||
                coef_last !== (j % 64 == 63)) begin
                bad++;
                $display("FAIL db_cycle%0d got v=%0b idx=%0d out=%0h last=%0b want v=1 idx=%0d out=%0h last=%0b",
                         j, coef_valid, coef_idx, coef_out, coef_last, zz[j % 64], base + zz[j % 64], (j % 64 == 63));
            end
            if (j == 19) begin
                total++;
                if (blk_ready !== 1'b1) begin
                    bad++; $display("FAIL db_ready got=%0b want=1", blk_ready);
                end
                load_block(6000, 1);
                blk_valid = 1'b1;
            end else begin
                blk_valid = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (coef_valid !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL db_end got v=%0b ovf=%0b want v=0 ovf=0", coef_valid, overflow);
        end
    endtask
`endif

    task automatic test_async_reset();
        load_block(2000, 1);
        out_ready = 1'b1;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        for (int i = 0; i <= 30; i++) begin
            total++;
            if (coef_valid !== 1'b1 || coef_idx !== 6'(zz[i]) || coef_out !== DATA_W'(2000 + zz[i])) begin
                bad++;
                $display("FAIL ar_step%0d got v=%0b idx=%0d out=%0h want v=1 idx=%0d out=%0h",
                         i, coef_valid, coef_idx, coef_out, zz[i], 2000 + zz[i]);
            end
            if (i < 30) @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (coef_valid !== 1'b0 || coef_last !== 1'b0 || coef_out !== '0) begin
            bad++; $display("FAIL ar_immediate got v=%0b last=%0b out=%0h want 0 0 0", coef_valid, coef_last, coef_out);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (coef_valid !== 1'b0 || overflow !== 1'b0 || blk_ready !== 1'b1) begin
            bad++; $display("FAIL ar_idle got v=%0b ovf=%0b rdy=%0b want v=0 ovf=0 rdy=1", coef_valid, overflow, blk_ready);
        end
        load_block(3000, 1);
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            total++;
            if (coef_valid !== 1'b1 || coef_idx !== 6'(zz[i]) || coef_out !== DATA_W'(3000 + zz[i]) || coef_last !== (i == 63)) begin
                bad++;
                $display("FAIL ar_new_step%0d got v=%0b idx=%0d out=%0h last=%0b want v=1 idx=%0d out=%0h last=%0b",
                         i, coef_valid, coef_idx, coef_out, coef_last, zz[i], 3000 + zz[i], (i == 63));
            end
            @(negedge clk);
        end
        total++;
        if (coef_valid !== 1'b0) begin
            bad++; $display("FAIL ar_end got v=%0b want=0", coef_valid);
        end
    endtask

    initial begin
        build_zz();
        test_reset();
        test_zigzag();
        test_raster();
        test_backpressure();
`ifdef DCT_ZZ_DOUBLEBUF_EN
        test_double_buffer();
`else
        test_overflow();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
